mul_div_unit: RTL
=================

# mul_div_unit

Multi-cycle multiply/divide unit for the five-stage pipeline, owning the HI/LO architectural registers. Operations are accepted from the execute stage. The unit sits on the requesting side of the stall/flush interface: it raises `busy_o`, which the hazard logic folds into `stall_f`/`stall_d` for any HI/LO consumer or new mul/div op in decode. Multiplies and HI/LO moves complete in one cycle; divides are iterative.

## Interface
- `DATA_W`, default 32: operand and HI/LO width.
- `clk_i`  input  1  system clock, all state updates on rising edge.
- `rst_ni`  input  1  asynchronous, active-low reset.
- `start_i`  input  1  execute stage holds a valid, non-flushed mul/div/MTHI/MTLO op this cycle.
- `op_i`  input  3  `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`, `MDU_MTHI`, `MDU_MTLO`.
- `a_i`  input  DATA_W  rs operand after E-stage forwarding (dividend / multiplicand / MT source).
- `b_i`  input  DATA_W  rt operand after E-stage forwarding (divisor / multiplier).
- `busy_o`  output  1  divide in progress; HI/LO not yet valid.
- `hi_o`  output  DATA_W  current HI register.
- `lo_o`  output  DATA_W  current LO register.

## Operation
- Reset: state `IDLE`, `hi_o`=0, `lo_o`=0, `busy_o`=0, iteration counter 0, all datapath regs 0. Reset is honored immediately in any state; a divide in progress is discarded.
- `start_i` is sampled only in `IDLE`. In `RUN`/`FIX` it is ignored; the hazard logic holds any new mul/div op in decode while `busy_o`=1, so a dropped start is a hazard-logic bug.
- MULT/MULTU: full 2·DATA_W product (signed resp. unsigned); {HI,LO} written at the sampling edge. No state change.
- MTHI/MTLO: HI (resp. LO) ← `a_i` at the sampling edge; other register unchanged.
- DIV/DIVU: operands latched; for DIV, magnitudes are taken and the signs of the quotient (a⊕b) and remainder (a) are recorded. State → `RUN`, counter = 0.
- `RUN`: restoring division, one quotient bit per cycle, MSB first; counter increments; after iteration DATA_W−1 → `FIX`.
- `FIX`: apply sign corrections (two's-complement negate where flagged). LO ← quotient, HI ← remainder. State → `IDLE`.
- Divide by zero (b=0): no exception. Runs the full sequence. Result is fixed: LO = all ones, HI = `a_i` as latched (signed and unsigned alike).
- DIV of most-negative by −1: LO = most-negative (wraps), HI = 0.
- HI/LO are never partially updated during `RUN`; they hold their pre-divide values until the `FIX` edge.

## Timing
- Edge 0 = rising edge sampling `start_i`=1 in `IDLE`.
- MULT/MULTU/MTHI/MTLO: `hi_o`/`lo_o` hold the new value from just after edge 0. A HI/LO reader entering E in the next cycle sees it with no stall. `busy_o` stays 0.
- DIV/DIVU: `busy_o`=1 from after edge 0 through edge DATA_W+1 (33 cycles for DATA_W=32). `RUN` covers edges 1..32, and `FIX` writes HI/LO at edge 33. `busy_o` is 0 and the result is visible right after edge 33.
- `busy_o` is a registered decode of the state (`RUN` or `FIX`), with no combinational path from inputs.
- Back-to-back: a new start may be sampled at edge 33+1 at the earliest (first cycle in `IDLE`).

## Structure
- Shared package `mdu_pkg`: `mdu_op_e` (op encodings, 3 bits), `mdu_state_e` (`IDLE`, `RUN`, `FIX`), `DIV_ITERS` = DATA_W.
- The decode/control stage imports `mdu_op_e` to drive `op_i`, so encodings are defined only in the package.
- One sub-module: `div_core`, an unsigned iterative restoring divider. It has start/done and quotient/remainder ports. `mul_div_unit` keeps the FSM wrapper, sign handling, multiply and HI/LO.

## Test plan
- MULT a=−3 (0xFFFFFFFD), b=7 → after edge 0: HI=0xFFFFFFFF, LO=0xFFFFFFEB, `busy_o` never 1. MULTU same operands → HI=0x00000006, LO=0xFFFFFFEB.
- DIV a=−7, b=2 → `busy_o` high exactly 33 cycles; afterwards LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). HI/LO unchanged from prior values during `busy_o`.
- DIVU a=0x80000000, b=0 → after 33 cycles LO=0xFFFFFFFF, HI=0x80000000. DIV a=0x80000000, b=−1 → LO=0x80000000, HI=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive cycles → HI/LO show those values one edge after each. `start_i` pulse with DIV at cycle 5 of a running divide → ignored; the first result is still correct.
- Assert `rst_ni`=0 asynchronously mid-RUN (cycle 10) → `busy_o`, HI, LO go 0 immediately without a clock edge. After release, a new DIVU 100/7 gives LO=14, HI=2.

Source files
------------

// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------------
// Module   : mdu_pkg
// Purpose  : Shared op encodings, FSM states and sizing for the mul/div unit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam int MDU_DATA_W = 32;
  localparam int DIV_ITERS  = MDU_DATA_W;

  // Decode drives op_i with these; no other file defines encodings.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// ----------------------------------------------------------------------------
// Module   : mdu_if
// Purpose  : Execute-stage to mul/div unit request and HI/LO result bundle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface mdu_if #(
  parameter int DATA_W = 32
);
  import mdu_pkg::*;

  logic              start_i;
  mdu_op_e           op_i;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic              busy_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  // Execute stage side
  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, hi_o, lo_o
  );

  // Mul/div unit side
  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, hi_o, lo_o
  );

endinterface

`default_nettype wire

// File: rtl/mul_div_unit_div_core.sv
// ----------------------------------------------------------------------------
// Module   : div_core
// Purpose  : Unsigned restoring divider, one quotient bit per cycle, MSB first.
//            done is high during the cycle whose edge retires the last bit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module div_core #(
  parameter int DATA_W = 32
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              start,
  input  wire logic [DATA_W-1:0] dividend,
  input  wire logic [DATA_W-1:0] divisor,
  output logic                   done,
  output logic [DATA_W-1:0]      quotient,
  output logic [DATA_W-1:0]      remainder
);

  localparam int CNT_W = $clog2(DATA_W);

  logic              running;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // Trial subtraction of the divisor from the partial remainder with the next
  // dividend bit shifted in; a set top bit means the trial went negative.
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
  end

  assign done      = running && (cnt == CNT_W'(DATA_W - 1));
  assign quotient  = quo;
  assign remainder = rem;

  // Load operands on start, then retire one quotient bit per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      running <= 1'b0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      quo     <= dividend;
      rem     <= '0;
      dvs     <= divisor;
    end else if (running) begin
      quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
      rem <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// Module   : mul_div_unit
// Purpose  : HI/LO owner: single-cycle multiply and moves, iterative divide
//            with sign fix-up, busy flag for the hazard unit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input wire logic clk_i,
  input wire logic rst_ni,
  mdu_if.slave     bus
);

  mdu_state_e        state;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [DATA_W-1:0] a_lat;

  logic              is_signed;
  logic              is_div;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] core_q;
  logic [DATA_W-1:0] core_r;
  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;

  // Operand conditioning: magnitudes for signed divide, both product flavours.
  always_comb begin
    is_signed  = (bus.op_i == MDU_DIV);
    is_div     = (bus.op_i == MDU_DIV) || (bus.op_i == MDU_DIVU);
    core_start = (state == IDLE) && bus.start_i && is_div;
    a_mag      = (is_signed && bus.a_i[DATA_W-1]) ? -bus.a_i : bus.a_i;
    b_mag      = (is_signed && bus.b_i[DATA_W-1]) ? -bus.b_i : bus.b_i;
    prod_s     = {{DATA_W{bus.a_i[DATA_W-1]}}, bus.a_i} *
                 {{DATA_W{bus.b_i[DATA_W-1]}}, bus.b_i};
    prod_u     = {{DATA_W{1'b0}}, bus.a_i} * {{DATA_W{1'b0}}, bus.b_i};
  end

  div_core #(.DATA_W(DATA_W)) u_div_core (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start     (core_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // Control FSM plus HI/LO; HI/LO only change in IDLE (single-cycle ops) or at FIX.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      busy     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_lat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            case (bus.op_i)
              MDU_MULT:  {hi, lo} <= prod_s;
              MDU_MULTU: {hi, lo} <= prod_u;
              MDU_MTHI:  hi <= bus.a_i;
              MDU_MTLO:  lo <= bus.a_i;
              MDU_DIV, MDU_DIVU: begin
                state    <= RUN;
                busy     <= 1'b1;
                neg_q    <= is_signed && (bus.a_i[DATA_W-1] ^ bus.b_i[DATA_W-1]);
                neg_r    <= is_signed && bus.a_i[DATA_W-1];
                div_zero <= (bus.b_i == '0);
                a_lat    <= bus.a_i;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (core_done) state <= FIX;
        end
        FIX: begin
          // Divide by zero returns a fixed pattern regardless of signedness.
          lo    <= div_zero ? '1    : (neg_q ? -core_q : core_q);
          hi    <= div_zero ? a_lat : (neg_r ? -core_r : core_r);
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o = busy;
  assign bus.hi_o   = hi;
  assign bus.lo_o   = lo;

endmodule

`default_nettype wire
